// File: rtl/arch_defs_pkg.sv
// Shared architecture definitions for the SAP computer: bus widths,
// opcode map and the seven-step instruction sequencer states.
package arch_defs_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 4;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LDA  = 4'h1,
        OP_ADD  = 4'h2,
        OP_SUB  = 4'h3,
        OP_STA  = 4'h4,
        OP_LDI  = 4'h5,
        OP_JMP  = 4'h6,
        OP_JC   = 4'h7,
        OP_JZ   = 4'h8,
        OP_JN   = 4'h9,
        OP_RSVA = 4'hA,
        OP_RSVB = 4'hB,
        OP_RSVC = 4'hC,
        OP_RSVD = 4'hD,
        OP_OUT  = 4'hE,
        OP_HLT  = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4,
        T5 = 3'd5,
        T6 = 3'd6
    } step_e;

    function automatic step_e next_step(input step_e s);
        case (s)
            T0:      return T1;
            T1:      return T2;
            T2:      return T3;
            T3:      return T4;
            T4:      return T5;
            T5:      return T6;
            default: return T0;
        endcase
    endfunction

endpackage

// File: rtl/program_counter.sv
// Program counter: increments modulo 2**WIDTH or loads a jump target.
module program_counter #(
    parameter int WIDTH = arch_defs_pkg::ADDR_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] counter_out
);

    always_ff @(posedge clk) begin
        if (reset) begin
            counter_out <= '0;
        end else if (load_i) begin
            counter_out <= load_val_i;
        end else if (inc_i) begin
            counter_out <= counter_out + 1'b1;
        end
    end

endmodule

// File: rtl/ram.sv
// Program/data memory: synchronous write, combinational read, no reset so
// a preloaded image survives CPU resets.
module ram
    import arch_defs_pkg::*;
#(
    parameter int AW = ADDR_WIDTH,
    parameter int DW = DATA_WIDTH
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[addr_i];

    task automatic dump(input logic [AW-1:0] addr, output logic [DW-1:0] data);
        data = mem[addr];
    endtask

endmodule

// File: rtl/register_nbit.sv
// Generic load-enabled register used for the A, B and output registers.
module register_nbit #(
    parameter int WIDTH = arch_defs_pkg::DATA_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] latched_data
);

    always_ff @(posedge clk) begin
        if (reset) begin
            latched_data <= '0;
        end else if (load_i) begin
            latched_data <= data_i;
        end
    end

endmodule

// File: rtl/sap_computer.sv
// SAP-style 8-bit CPU: seven-step fetch/decode/execute sequencer, inline
// ALU and flag logic, with A/B/O registers, PC and RAM as sub-blocks.
module sap_computer #(
    parameter int DATA_WIDTH = arch_defs_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = arch_defs_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [DATA_WIDTH-1:0] out_val,
    output logic                  flag_zero_o,
    output logic                  flag_carry_o,
    output logic                  flag_negative_o
);
    import arch_defs_pkg::*;

    logic [ADDR_WIDTH-1:0] pc_value;
    logic [ADDR_WIDTH-1:0] mar_q;
    logic [DATA_WIDTH-1:0] ir_q;
    step_e                 step_q;
    logic                  halt_q;
    logic                  carry_q;
    logic                  zero_q;
    logic                  negative_q;

    logic [DATA_WIDTH-1:0] a_value;
    logic [DATA_WIDTH-1:0] b_value;
    logic [DATA_WIDTH-1:0] o_value;
    logic [DATA_WIDTH-1:0] ram_rdata;

    opcode_e               op;
    logic [ADDR_WIDTH-1:0] operand;
    logic                  mem_op;

    assign op      = opcode_e'(ir_q[DATA_WIDTH-1 -: 4]);
    assign operand = ir_q[ADDR_WIDTH-1:0];
    assign mem_op  = op inside {OP_LDA, OP_ADD, OP_SUB, OP_STA};

    // Nine-bit sum/difference; bit DATA_WIDTH is carry-out or borrow.
    logic [DATA_WIDTH:0] sum_w;
    logic [DATA_WIDTH:0] diff_w;

    assign sum_w  = {1'b0, a_value} + {1'b0, b_value};
    assign diff_w = {1'b0, a_value} - {1'b0, b_value};

    logic                  run;
    logic                  take_branch;
    logic                  writes_a;
    logic [DATA_WIDTH-1:0] a_d;
    logic                  carry_d;
    logic                  pc_inc;
    logic                  pc_load;
    logic                  a_load;
    logic                  b_load;
    logic                  o_load;
    logic                  ram_we;

    always_comb begin
        run         = !halt_q;
        take_branch = 1'b0;
        writes_a    = 1'b0;
        a_d         = ram_rdata;
        carry_d     = 1'b0;

        case (op)
            OP_JMP:  take_branch = 1'b1;
            OP_JC:   take_branch = carry_q;
            OP_JZ:   take_branch = zero_q;
            OP_JN:   take_branch = negative_q;
            default: take_branch = 1'b0;
        endcase

        case (op)
            OP_LDA: begin
                writes_a = 1'b1;
                a_d      = ram_rdata;
                carry_d  = 1'b0;
            end
            OP_ADD: begin
                writes_a = 1'b1;
                a_d      = sum_w[DATA_WIDTH-1:0];
                carry_d  = sum_w[DATA_WIDTH];
            end
            OP_SUB: begin
                writes_a = 1'b1;
                a_d      = diff_w[DATA_WIDTH-1:0];
                carry_d  = !diff_w[DATA_WIDTH];
            end
            OP_LDI: begin
                writes_a = 1'b1;
                a_d      = DATA_WIDTH'(ir_q[3:0]);
                carry_d  = 1'b0;
            end
            default: writes_a = 1'b0;
        endcase

        pc_inc  = run && (step_q == T1);
        pc_load = run && (step_q == T3) && take_branch;
        o_load  = run && (step_q == T3) && (op == OP_OUT);
        ram_we  = run && (step_q == T4) && (op == OP_STA);
        b_load  = run && (step_q == T4) && (op inside {OP_ADD, OP_SUB});
        a_load  = run && (step_q == T5) && writes_a;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mar_q      <= '0;
            ir_q       <= '0;
            step_q     <= T0;
            halt_q     <= 1'b0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            negative_q <= 1'b0;
        end else if (run) begin
            case (step_q)
                T0:      mar_q <= pc_value;
                T1:      ir_q  <= ram_rdata;
                T3:      if (mem_op) mar_q <= operand;
                default: ;
            endcase

            if (a_load) begin
                carry_q    <= carry_d;
                zero_q     <= (a_d == '0);
                negative_q <= a_d[DATA_WIDTH-1];
            end

            // HLT parks the sequencer at T3 with PC already incremented.
            if ((step_q == T3) && (op == OP_HLT)) begin
                halt_q <= 1'b1;
            end else begin
                step_q <= next_step(step_q);
            end
        end
    end

    program_counter #(
        .WIDTH (ADDR_WIDTH)
    ) u_program_counter (
        .clk         (clk),
        .reset       (reset),
        .inc_i       (pc_inc),
        .load_i      (pc_load),
        .load_val_i  (operand),
        .counter_out (pc_value)
    );

    ram #(
        .AW (ADDR_WIDTH),
        .DW (DATA_WIDTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .addr_i  (mar_q),
        .wdata_i (a_value),
        .rdata_o (ram_rdata)
    );

    register_nbit #(
        .WIDTH (DATA_WIDTH)
    ) u_register_A (
        .clk          (clk),
        .reset        (reset),
        .load_i       (a_load),
        .data_i       (a_d),
        .latched_data (a_value)
    );

    register_nbit #(
        .WIDTH (DATA_WIDTH)
    ) u_register_B (
        .clk          (clk),
        .reset        (reset),
        .load_i       (b_load),
        .data_i       (ram_rdata),
        .latched_data (b_value)
    );

    register_nbit #(
        .WIDTH (DATA_WIDTH)
    ) u_register_o (
        .clk          (clk),
        .reset        (reset),
        .load_i       (o_load),
        .data_i       (a_value),
        .latched_data (o_value)
    );

    assign out_val         = o_value;
    assign flag_zero_o     = zero_q;
    assign flag_carry_o    = carry_q;
    assign flag_negative_o = negative_q;

endmodule

// File: tb/tb_sap_computer.sv
// Bench for sap_computer: an instruction-level ISA model is stepped once per
// seven clocks and compared against the CPU state at every instruction boundary.
module tb_sap_computer;

    logic       clk;
    logic       reset;
    logic [7:0] out_val;
    logic       flag_zero_o;
    logic       flag_carry_o;
    logic       flag_negative_o;

    int checks = 0;
    int errors = 0;

    sap_computer dut (
        .clk             (clk),
        .reset           (reset),
        .out_val         (out_val),
        .flag_zero_o     (flag_zero_o),
        .flag_carry_o    (flag_carry_o),
        .flag_negative_o (flag_negative_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural model state.
    logic [7:0] m_mem [0:15];
    logic [3:0] m_pc;
    logic [7:0] m_a, m_b, m_o;
    logic       m_c, m_z, m_n, m_halt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_image(input logic [7:0] img [0:15]);
        logic [3:0] idx;
        for (int i = 0; i < 16; i++) begin
            idx = 4'(i);
            dut.u_ram.mem[idx] = img[idx];
            m_mem[idx] = img[idx];
        end
    endtask

    task automatic model_reset();
        m_pc = 4'h0; m_a = 8'h00; m_b = 8'h00; m_o = 8'h00;
        m_c = 1'b0; m_z = 1'b0; m_n = 1'b0; m_halt = 1'b0;
    endtask

    task automatic check_zero_state(input string tag);
        check({tag, "_pc"},   32'(dut.u_program_counter.counter_out), 0);
        check({tag, "_mar"},  32'(dut.mar_q), 0);
        check({tag, "_ir"},   32'(dut.ir_q), 0);
        check({tag, "_step"}, 32'(dut.step_q), 0);
        check({tag, "_A"},    32'(dut.u_register_A.latched_data), 0);
        check({tag, "_B"},    32'(dut.u_register_B.latched_data), 0);
        check({tag, "_O"},    32'(out_val), 0);
        check({tag, "_flags"}, {29'd0, flag_carry_o, flag_zero_o, flag_negative_o}, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        check_zero_state("reset");
    endtask

    task automatic model_step(output logic [7:0] ir);
        logic [3:0] opd;
        logic [8:0] t;
        ir = m_mem[m_pc];
        if (m_halt) return;
        opd = ir[3:0];
        m_pc = m_pc + 4'd1;
        case (ir[7:4])
            4'h1: begin m_a = m_mem[opd]; m_c = 1'b0; end
            4'h2: begin
                m_b = m_mem[opd];
                t = {1'b0, m_a} + {1'b0, m_b};
                m_c = t[8]; m_a = t[7:0];
            end
            4'h3: begin
                m_b = m_mem[opd];
                m_c = (m_a >= m_b);
                m_a = m_a - m_b;
            end
            4'h4: m_mem[opd] = m_a;
            4'h5: begin m_a = {4'h0, opd}; m_c = 1'b0; end
            4'h6: m_pc = opd;
            4'h7: if (m_c) m_pc = opd;
            4'h8: if (m_z) m_pc = opd;
            4'h9: if (m_n) m_pc = opd;
            4'hE: m_o = m_a;
            4'hF: m_halt = 1'b1;
            default: ;
        endcase
        if (ir[7:4] inside {4'h1, 4'h2, 4'h3, 4'h5}) begin
            m_z = (m_a == 8'h00);
            m_n = m_a[7];
        end
    endtask

    task automatic compare_all();
        logic [3:0] idx;
        check("pc",  32'(dut.u_program_counter.counter_out), 32'(m_pc));
        check("A",   32'(dut.u_register_A.latched_data), 32'(m_a));
        check("B",   32'(dut.u_register_B.latched_data), 32'(m_b));
        check("O",   32'(dut.u_register_o.latched_data), 32'(m_o));
        check("out_val", 32'(out_val), 32'(m_o));
        check("Z", 32'(flag_zero_o), 32'(m_z));
        check("C", 32'(flag_carry_o), 32'(m_c));
        check("N", 32'(flag_negative_o), 32'(m_n));
        for (int i = 0; i < 16; i++) begin
            idx = 4'(i);
            check("mem", 32'(dut.u_ram.mem[idx]), 32'(m_mem[idx]));
        end
    endtask

    task automatic run_instr();
        logic [7:0] ir;
        repeat (7) @(negedge clk);
        model_step(ir);
        $display("instr ir=%02h pc=%0h A=%02h B=%02h O=%02h CZN=%b%b%b halt=%b",
                 ir, m_pc, m_a, m_b, m_o, m_c, m_z, m_n, m_halt);
        compare_all();
    endtask

    logic [7:0] img_p1 [0:15];
    logic [7:0] img_p2 [0:15];
    logic [7:0] img_nop [0:15];
    logic [7:0] img_rnd [0:15];

    task automatic run_prog1();
        run_instr();  // LDA F
        check("p1_lda_A", 32'(dut.u_register_A.latched_data), 32'h0FF);
        check("p1_lda_pc", 32'(dut.u_program_counter.counter_out), 1);
        check("p1_lda_ZNC", {29'd0, flag_zero_o, flag_negative_o, flag_carry_o}, 32'b010);
        run_instr();  // ADD E
        check("p1_add_B", 32'(dut.u_register_B.latched_data), 32'h01);
        check("p1_add_A", 32'(dut.u_register_A.latched_data), 32'h00);
        check("p1_add_CZ", {30'd0, flag_carry_o, flag_zero_o}, 32'b11);
        run_instr();  // JC 6
        check("p1_jc_pc", 32'(dut.u_program_counter.counter_out), 32'h6);
        check("p1_jc_A", 32'(dut.u_register_A.latched_data), 32'h00);
        run_instr();  // LDI 1
        check("p1_ldi_A", 32'(dut.u_register_A.latched_data), 32'h01);
        check("p1_ldi_pc", 32'(dut.u_program_counter.counter_out), 32'h7);
        check("p1_ldi_ZC", {30'd0, flag_zero_o, flag_carry_o}, 32'b00);
        run_instr();  // JC A, not taken
        check("p1_jcn_pc", 32'(dut.u_program_counter.counter_out), 32'h8);
        run_instr();  // OUTA
        check("p1_out_O", 32'(dut.u_register_o.latched_data), 32'h01);
        check("p1_out_val", 32'(out_val), 32'h01);
        check("p1_out_pc", 32'(dut.u_program_counter.counter_out), 32'h9);
        run_instr();  // HLT
        check("p1_hlt_pc", 32'(dut.u_program_counter.counter_out), 32'hA);
        for (int k = 0; k < 56; k++) begin
            @(negedge clk);
            check("p1_halt_pc", 32'(dut.u_program_counter.counter_out), 32'hA);
            check("p1_halt_A", 32'(dut.u_register_A.latched_data), 32'h01);
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            img_p1[i]  = 8'h00;
            img_p2[i]  = 8'h00;
            img_nop[i] = 8'h00;
        end
        img_p1[0] = 8'h1F; img_p1[1] = 8'h2E; img_p1[2] = 8'h76; img_p1[6] = 8'h51;
        img_p1[7] = 8'h7A; img_p1[8] = 8'hE0; img_p1[9] = 8'hF0; img_p1[14] = 8'h01;
        img_p1[15] = 8'hFF;

        img_p2[0] = 8'h55; img_p2[1] = 8'h3C; img_p2[2] = 8'h85; img_p2[3] = 8'hF0;
        img_p2[4] = 8'hF0; img_p2[5] = 8'h59; img_p2[6] = 8'h4D; img_p2[7] = 8'h50;
        img_p2[8] = 8'h1D; img_p2[9] = 8'hE0; img_p2[10] = 8'hF0; img_p2[12] = 8'h05;

        @(negedge clk);
        load_image(img_p1);
        do_reset();
        run_prog1();

        // Reset in the middle of ADD, then the program must replay identically.
        do_reset();
        run_instr();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_zero_state("midreset");
        do_reset();
        run_prog1();

        load_image(img_p2);
        do_reset();
        run_instr();  // LDI 5
        run_instr();  // SUB C
        check("p2_sub_A", 32'(dut.u_register_A.latched_data), 32'h00);
        check("p2_sub_ZC", {30'd0, flag_zero_o, flag_carry_o}, 32'b11);
        run_instr();  // JZ 5
        check("p2_jz_pc", 32'(dut.u_program_counter.counter_out), 32'h5);
        run_instr();  // LDI 9
        run_instr();  // STA D
        check("p2_sta_mem", 32'(dut.u_ram.mem[4'hD]), 32'h09);
        run_instr();  // LDI 0
        run_instr();  // LDA D
        check("p2_lda_A", 32'(dut.u_register_A.latched_data), 32'h09);
        run_instr();  // OUTA
        check("p2_out_val", 32'(out_val), 32'h09);
        run_instr();  // HLT

        // PC wraps from F back to 0.
        load_image(img_nop);
        do_reset();
        for (int k = 0; k < 16; k++) run_instr();
        check("wrap_pc", 32'(dut.u_program_counter.counter_out), 32'h0);
        run_instr();
        check("wrap_pc1", 32'(dut.u_program_counter.counter_out), 32'h1);

        for (int p = 0; p < 20; p++) begin
            for (int i = 0; i < 16; i++) img_rnd[i] = 8'($urandom);
            load_image(img_rnd);
            do_reset();
            for (int k = 0; k < 40; k++) run_instr();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
